ami_channel_steer: RTL and testbench

AMI_CHANNEL_STEER -- requirements
Module: ami_channel_steer

---
 rtl/ami_channel_steer_pkg.sv | 57 +++++
 rtl/ami_channel_steer_fifo.sv | 50 +++++
 rtl/ami_channel_steer.sv | 151 +++++++++++++++
 tb/tb_ami_channel_steer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ami_channel_steer_pkg.sv
// Shared AMI request/response payloads and steering helpers.
package ami_channel_steer_pkg;

  localparam int unsigned AMI_APP_BITS  = 3;
  localparam int unsigned AMI_PORT_BITS = 4;
  localparam int unsigned AMI_ADDR_BITS = 64;
  localparam int unsigned AMI_SIZE_BITS = 8;
  localparam int unsigned AMI_CHAN_BITS = 3;

  typedef enum logic [1:0] {
    MODE_SINGLE = 2'd0,
    MODE_PORT   = 2'd1,
    MODE_INTLV  = 2'd2,
    MODE_RSVD   = 2'd3
  } ami_mode_e;

  typedef struct packed {
    logic                     valid;
    logic                     is_write;
    logic [AMI_ADDR_BITS-1:0] addr;
    logic [AMI_SIZE_BITS-1:0] size;
  } AMIRequest;

  typedef struct packed {
    logic                     valid;
    logic                     is_write;
    logic [AMI_ADDR_BITS-1:0] addr;
    logic [AMI_SIZE_BITS-1:0] size;
  } AMIReq;

  typedef struct packed {
    logic                     valid;
    logic [AMI_APP_BITS-1:0]  app;
    logic [AMI_PORT_BITS-1:0] port;
    logic [AMI_CHAN_BITS-1:0] channel;
    logic [AMI_SIZE_BITS-1:0] size;
  } AMITag;

  // Queue entry: the request plus the origin identity captured at enqueue.
  typedef struct packed {
    AMIRequest                req;
    logic [AMI_APP_BITS-1:0]  app;
    logic [AMI_PORT_BITS-1:0] port;
  } ami_entry_t;

  // Squeeze the channel-select bits out of an interleaved address.
  function automatic logic [AMI_ADDR_BITS-1:0] intlv_addr(
    input logic [AMI_ADDR_BITS-1:0] addr,
    input int unsigned              shift,
    input int unsigned              cb
  );
    logic [AMI_ADDR_BITS-1:0] low_mask;
    low_mask = (64'd1 << shift) - 64'd1;
    return ((addr >> (shift + cb)) << shift) | (addr & low_mask);
  endfunction

endpackage

// File: rtl/ami_channel_steer_fifo.sv
// Request queue: 2^LOG_DEPTH entries, head presented combinationally.
module ami_channel_steer_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned LOG_DEPTH = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned DEPTH = 2 ** LOG_DEPTH;
  localparam int unsigned PW    = LOG_DEPTH;
  localparam int unsigned CW    = LOG_DEPTH + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ami_channel_steer.sv
// Queues translated AMI requests and steers each to one memory channel,
// enforcing range limits, per-channel read credits and tag back-pressure.
module ami_channel_steer
  import ami_channel_steer_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS    = 4,
  parameter int unsigned LOG_DEPTH       = 3,
  parameter int unsigned INTLV_SHIFT     = 6,
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enabled,
  input  logic [1:0]               cfg_mode,
  input  logic [63:0]              cfg_limit,
  input  logic [AMI_APP_BITS-1:0]  srcApp,
  input  logic [AMI_PORT_BITS-1:0] srcPort,
  input  AMIRequest                req_in,
  output logic                     req_grant,
  output AMIReq                    req_out [NUM_CHANNELS],
  input  logic [NUM_CHANNELS-1:0]  req_out_grant,
  output AMITag                    tag_out,
  input  logic                     tag_full,
  input  logic [NUM_CHANNELS-1:0]  rd_done,
  output logic                     fault,
  output logic [15:0]              fault_count
);

  localparam int unsigned CB  = $clog2(NUM_CHANNELS);
  localparam int unsigned SW  = (CB == 0) ? 1 : CB;
  localparam int unsigned CRW = $clog2(MAX_OUTSTANDING + 1);

  ami_entry_t                in_entry;
  ami_entry_t                head;
  logic                      empty;
  logic                      full;
  ami_mode_e                 mode;
  logic [SW-1:0]             sel;
  logic [AMI_ADDR_BITS-1:0]  out_addr;
  logic                      head_live;
  logic                      in_range;
  logic                      can_issue;
  logic                      granted;
  logic                      drop;
  logic                      pop;
  logic                      deq_read;
  logic [NUM_CHANNELS-1:0]   credit_ok;

  assign in_entry.req  = req_in;
  assign in_entry.app  = srcApp;
  assign in_entry.port = srcPort;

  // Reset gates the grant so nothing is accepted while rst_n is low.
  assign req_grant = rst_n && enabled && req_in.valid && !full;

  ami_channel_steer_fifo #(
    .WIDTH    ($bits(ami_entry_t)),
    .LOG_DEPTH(LOG_DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset_n  (rst_n),
    .push     (req_grant),
    .push_data(in_entry),
    .pop      (pop),
    .head     (head),
    .empty    (empty),
    .full     (full)
  );

  // Channel select and address translation for the head entry.
  always_comb begin
    mode     = (NUM_CHANNELS == 1) ? MODE_SINGLE : ami_mode_e'(cfg_mode);
    sel      = '0;
    out_addr = head.req.addr;
    case (mode)
      MODE_PORT: begin
        sel = SW'(32'(head.port) % NUM_CHANNELS);
      end
      MODE_INTLV: begin
        sel      = SW'(head.req.addr >> INTLV_SHIFT);
        out_addr = intlv_addr(head.req.addr, INTLV_SHIFT, CB);
      end
      default: begin
        sel = '0;
      end
    endcase
  end

  assign head_live = rst_n && !empty && head.req.valid;
  assign in_range  = (head.req.addr < cfg_limit);
  assign drop      = head_live && !in_range;
  assign can_issue = head_live && in_range &&
                     (head.req.is_write || (!tag_full && credit_ok[sel]));
  assign granted   = can_issue && req_out_grant[sel];
  assign deq_read  = granted && !head.req.is_write;
  assign pop       = granted || drop;

  // Per-channel outstanding-read credit counters.
  for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_credit
    logic [CRW-1:0] count;
    logic           inc;
    logic           dec;

    assign inc           = deq_read && (sel == SW'(ch));
    assign dec           = rd_done[ch] && (count != '0);
    assign credit_ok[ch] = (count < CRW'(MAX_OUTSTANDING));

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        count <= '0;
      end else if (inc && !dec) begin
        count <= count + CRW'(1);
      end else if (dec && !inc) begin
        count <= count - CRW'(1);
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      req_out[i] = '0;
      if (SW'(i) == sel) begin
        req_out[i].valid    = can_issue;
        req_out[i].is_write = head.req.is_write;
        req_out[i].addr     = out_addr;
        req_out[i].size     = head.req.size;
      end
    end
  end

  always_comb begin
    tag_out         = '0;
    tag_out.valid   = deq_read;
    tag_out.app     = head.app;
    tag_out.port    = head.port;
    tag_out.channel = AMI_CHAN_BITS'(sel);
    tag_out.size    = head.req.size;
  end

  // Sticky fault flag and saturating drop counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fault       <= 1'b0;
      fault_count <= '0;
    end else if (drop) begin
      fault <= 1'b1;
      if (fault_count != 16'hFFFF) fault_count <= fault_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_ami_channel_steer.sv
// Directed scenarios plus a randomized run against a queue-based reference model.
module tb_ami_channel_steer;
  import ami_channel_steer_pkg::*;

  localparam int unsigned NCH   = 4;
  localparam int unsigned SHIFT = 6;
  localparam int unsigned MAXO  = 16;
  localparam int unsigned DEPTH = 8;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     enabled;
  logic [1:0]               cfg_mode;
  logic [63:0]              cfg_limit;
  logic [AMI_APP_BITS-1:0]  srcApp;
  logic [AMI_PORT_BITS-1:0] srcPort;
  AMIRequest                req_in;
  logic                     req_grant;
  AMIReq                    req_out [NCH];
  logic [NCH-1:0]           req_out_grant;
  AMITag                    tag_out;
  logic                     tag_full;
  logic [NCH-1:0]           rd_done;
  logic                     fault;
  logic [15:0]              fault_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ami_channel_steer #(
    .NUM_CHANNELS(NCH), .LOG_DEPTH(3), .INTLV_SHIFT(SHIFT), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enabled(enabled), .cfg_mode(cfg_mode),
    .cfg_limit(cfg_limit), .srcApp(srcApp), .srcPort(srcPort), .req_in(req_in),
    .req_grant(req_grant), .req_out(req_out), .req_out_grant(req_out_grant),
    .tag_out(tag_out), .tag_full(tag_full), .rd_done(rd_done), .fault(fault),
    .fault_count(fault_count)
  );

  // Reference model state
  typedef struct {
    bit                       wr;
    logic [63:0]              addr;
    logic [7:0]               size;
    logic [AMI_APP_BITS-1:0]  app;
    logic [AMI_PORT_BITS-1:0] port;
  } ent_t;

  ent_t        mq[$];
  int          m_credit [NCH];
  bit          m_fault;
  int          m_fcount;
  bit          e_grant;
  bit [NCH-1:0] e_valid;
  int          e_sel;
  logic [63:0] e_addr;
  bit          e_tag;
  bit          e_pop;
  bit          e_drop;
  ent_t        e_head;

  function automatic logic [NCH-1:0] valids();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = req_out[i].valid;
    return v;
  endfunction

  task automatic to_check(); @(negedge clk); endtask
  task automatic to_drive(); @(posedge clk); #1; endtask

  task automatic drive_idle();
    enabled = 1'b1; req_in = '0; srcApp = '0; srcPort = '0;
    req_out_grant = '0; rd_done = '0; tag_full = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; drive_idle(); cfg_mode = 2'd0; cfg_limit = '1;
    repeat (2) to_drive();
    rst_n = 1'b1;
  endtask

  task automatic put_req(input bit wr, input logic [63:0] a, input logic [7:0] sz);
    req_in.valid = 1'b1; req_in.is_write = wr; req_in.addr = a; req_in.size = sz;
  endtask

  // Expected outputs for this cycle, from the steering rules applied to the model queue.
  task automatic model_eval();
    int md;
    e_grant = rst_n && enabled && req_in.valid && (mq.size() < DEPTH);
    e_valid = '0; e_tag = 0; e_pop = 0; e_drop = 0; e_sel = 0; e_addr = '0;
    if (rst_n && mq.size() > 0) begin
      e_head = mq[0];
      md = (cfg_mode == 2'd3) ? 0 : int'(cfg_mode);
      e_addr = e_head.addr;
      if (md == 1) e_sel = int'(e_head.port) % NCH;
      if (md == 2) begin
        e_sel  = int'((e_head.addr >> SHIFT) % NCH);
        e_addr = ((e_head.addr >> (SHIFT + 2)) << SHIFT) + (e_head.addr % (64'd1 << SHIFT));
      end
      if (e_head.addr >= cfg_limit) begin
        e_drop = 1; e_pop = 1;
      end else if (e_head.wr || (!tag_full && m_credit[e_sel] < MAXO)) begin
        e_valid[e_sel] = 1'b1;
        if (req_out_grant[e_sel]) begin
          e_pop = 1; e_tag = !e_head.wr;
        end
      end
    end
  endtask

  task automatic model_commit();
    ent_t n;
    if (!rst_n) begin
      mq.delete(); m_fault = 0; m_fcount = 0;
      for (int i = 0; i < NCH; i++) m_credit[i] = 0;
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      if (rd_done[i] && m_credit[i] > 0) m_credit[i]--;
      if (e_tag && e_sel == i) m_credit[i]++;
    end
    if (e_drop) begin
      m_fault = 1;
      if (m_fcount < 65535) m_fcount++;
    end
    if (e_pop) void'(mq.pop_front());
    if (e_grant) begin
      n.wr = req_in.is_write; n.addr = req_in.addr; n.size = req_in.size;
      n.app = srcApp; n.port = srcPort;
      mq.push_back(n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; drive_idle(); cfg_mode = 2'd0; cfg_limit = '1;
    put_req(0, 64'h40, 8'd8); req_out_grant = '1;
    to_drive();
    to_check();
    checks++; if (req_grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %b want 0", req_grant); end
    checks++; if (valids() !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b want 0000", valids()); end
    checks++; if (tag_out.valid !== 1'b0) begin errors++; $display("FAIL reset_tag: got %b want 0", tag_out.valid); end
    checks++; if (fault !== 1'b0 || fault_count !== 16'd0) begin errors++; $display("FAIL reset_fault: got %b/%0d want 0/0", fault, fault_count); end
    to_drive();
    drive_idle(); rst_n = 1'b1;
  endtask

  task automatic test_intlv_read();
    do_reset(); cfg_mode = 2'd2;
    put_req(0, 64'hC0, 8'd4); srcApp = 3'd5; srcPort = 4'd9;
    to_check();
    checks++; if (req_grant !== 1'b1) begin errors++; $display("FAIL intlv_rd_grant: got %b want 1", req_grant); end
    to_drive(); req_in.valid = 1'b0; req_out_grant = 4'b1000;
    to_check();
    checks++; if (valids() !== 4'b1000) begin errors++; $display("FAIL intlv_rd_valid: got %b want 1000", valids()); end
    checks++; if (req_out[3].addr !== 64'h0) begin errors++; $display("FAIL intlv_rd_addr: got %h want 0", req_out[3].addr); end
    checks++;
    if (tag_out.valid !== 1'b1 || tag_out.channel !== 3'd3 || tag_out.app !== 3'd5 ||
        tag_out.port !== 4'd9 || tag_out.size !== 8'd4) begin
      errors++; $display("FAIL intlv_rd_tag: got %b ch%0d app%0d port%0d sz%0d want 1 ch3 app5 port9 sz4",
                         tag_out.valid, tag_out.channel, tag_out.app, tag_out.port, tag_out.size);
    end
    to_drive(); req_out_grant = '0;
    to_check();
    checks++; if (valids() !== 4'b0000 || tag_out.valid !== 1'b0) begin errors++; $display("FAIL intlv_rd_once: got %b/%b want 0000/0", valids(), tag_out.valid); end
    to_drive();
  endtask

  task automatic test_intlv_write();
    do_reset(); cfg_mode = 2'd2;
    put_req(1, 64'h1234_5678, 8'd16);
    to_drive(); req_in.valid = 1'b0; req_out_grant = '1;
    to_check();
    checks++; if (valids() !== 4'b0010) begin errors++; $display("FAIL intlv_wr_valid: got %b want 0010", valids()); end
    checks++; if (req_out[1].addr !== 64'h048D_15B8) begin errors++; $display("FAIL intlv_wr_addr: got %h want 048d15b8", req_out[1].addr); end
    checks++; if (tag_out.valid !== 1'b0) begin errors++; $display("FAIL intlv_wr_tag: got %b want 0", tag_out.valid); end
    to_drive();
  endtask

  task automatic test_fault();
    do_reset(); cfg_limit = 64'h1000; req_out_grant = '1;
    put_req(0, 64'h1000, 8'd8);
    to_drive(); put_req(0, 64'h0FC0, 8'd8);
    to_check();
    checks++; if (valids() !== 4'b0000 || tag_out.valid !== 1'b0) begin errors++; $display("FAIL fault_drop: got %b/%b want 0000/0", valids(), tag_out.valid); end
    to_drive(); req_in.valid = 1'b0;
    to_check();
    checks++; if (fault !== 1'b1 || fault_count !== 16'd1) begin errors++; $display("FAIL fault_flag: got %b/%0d want 1/1", fault, fault_count); end
    checks++; if (valids() !== 4'b0001 || req_out[0].addr !== 64'h0FC0 || tag_out.valid !== 1'b1) begin
      errors++; $display("FAIL fault_next: got %b %h %b want 0001 fc0 1", valids(), req_out[0].addr, tag_out.valid);
    end
    to_drive(); cfg_limit = '1;
  endtask

  task automatic test_credit();
    do_reset(); req_out_grant = 4'b0001;
    for (int k = 0; k <= 16; k++) begin
      put_req(0, 64'(k) << 4, 8'd1);
      to_check();
      checks++; if (valids() !== ((k == 0) ? 4'b0000 : 4'b0001)) begin errors++; $display("FAIL credit_fill%0d: got %b", k, valids()); end
      to_drive();
    end
    put_req(1, 64'h500, 8'd2);
    to_check();
    checks++; if (valids() !== 4'b0000 || tag_out.valid !== 1'b0) begin errors++; $display("FAIL credit_held: got %b/%b want 0000/0", valids(), tag_out.valid); end
    to_drive(); req_in.valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) rd_done = 4'b0001;
      to_check();
      checks++; if (valids() !== 4'b0000) begin errors++; $display("FAIL credit_wr_blocked%0d: got %b want 0000", k, valids()); end
      to_drive(); rd_done = '0;
    end
    to_check();
    checks++; if (valids() !== 4'b0001 || req_out[0].is_write !== 1'b0 || tag_out.valid !== 1'b1) begin
      errors++; $display("FAIL credit_release: got %b wr%b tag%b want 0001 wr0 tag1", valids(), req_out[0].is_write, tag_out.valid);
    end
    to_drive();
    to_check();
    checks++; if (valids() !== 4'b0001 || req_out[0].is_write !== 1'b1 || tag_out.valid !== 1'b0) begin
      errors++; $display("FAIL credit_wr_after: got %b wr%b tag%b want 0001 wr1 tag0", valids(), req_out[0].is_write, tag_out.valid);
    end
    to_drive(); put_req(1, 64'h900, 8'd2);
    to_drive(); req_in.valid = 1'b0;
    to_check();
    checks++; if (valids() !== 4'b0001 || req_out[0].is_write !== 1'b1) begin errors++; $display("FAIL credit_wr_alone: got %b wr%b want 0001 wr1", valids(), req_out[0].is_write); end
    to_drive();
  endtask

  task automatic test_tag_full();
    do_reset(); tag_full = 1'b1; req_out_grant = '1;
    put_req(0, 64'h80, 8'd2);
    to_drive(); req_in.valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      to_check();
      checks++; if (valids() !== 4'b0000 || tag_out.valid !== 1'b0) begin errors++; $display("FAIL tagfull_hold%0d: got %b/%b want 0000/0", k, valids(), tag_out.valid); end
      to_drive();
    end
    tag_full = 1'b0;
    to_check();
    checks++; if (valids() !== 4'b0001 || req_out[0].addr !== 64'h80 || tag_out.valid !== 1'b1) begin
      errors++; $display("FAIL tagfull_release: got %b %h %b want 0001 80 1", valids(), req_out[0].addr, tag_out.valid);
    end
    to_drive();
    to_check();
    checks++; if (valids() !== 4'b0000) begin errors++; $display("FAIL tagfull_single: got %b want 0000", valids()); end
    to_drive();
  endtask

  task automatic test_full();
    do_reset();
    for (int k = 0; k <= 8; k++) begin
      put_req(1, 64'(k) << 6, 8'd1);
      to_check();
      checks++; if (req_grant !== (k < 8)) begin errors++; $display("FAIL full_grant%0d: got %b want %b", k, req_grant, k < 8); end
      to_drive();
    end
    req_out_grant = '1;
    to_check();
    checks++; if (req_grant !== 1'b0 || valids() !== 4'b0001) begin errors++; $display("FAIL full_deq_enq: got %b/%b want 0/0001", req_grant, valids()); end
    to_drive();
    to_check();
    checks++; if (req_grant !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b want 1", req_grant); end
    to_drive(); rst_n = 1'b0;
    to_check();
    checks++; if (req_grant !== 1'b0 || valids() !== 4'b0000 || tag_out.valid !== 1'b0) begin
      errors++; $display("FAIL full_rst: got %b/%b/%b want 0/0000/0", req_grant, valids(), tag_out.valid);
    end
    to_drive(); rst_n = 1'b1; req_in.valid = 1'b0;
    to_check();
    checks++; if (valids() !== 4'b0000) begin errors++; $display("FAIL full_rst_flushed: got %b want 0000", valids()); end
    to_drive();
  endtask

  task automatic test_random();
    bit [NCH-1:0] got;
    rst_n = 1'b0; drive_idle();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc >= 2) rst_n = ($urandom_range(0, 199) != 0);
      enabled = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) cfg_mode = 2'($urandom_range(0, 3));
      cfg_limit = (cyc < 1500) ? '1 : 64'h4000;
      req_in.valid    = ($urandom_range(0, 9) < 6);
      req_in.is_write = $urandom_range(0, 1);
      req_in.addr     = (cyc < 1500) ? {$urandom, $urandom} : 64'($urandom_range(0, 32'h7FFF));
      req_in.size     = 8'($urandom);
      srcApp  = AMI_APP_BITS'($urandom);
      srcPort = AMI_PORT_BITS'($urandom);
      req_out_grant = NCH'($urandom | $urandom);
      rd_done       = NCH'($urandom & $urandom);
      tag_full      = ($urandom_range(0, 4) == 0);
      to_check();
      model_eval();
      got = valids();
      checks++; if (req_grant !== e_grant) begin errors++; $display("FAIL rnd_grant@%0d: got %b want %b", cyc, req_grant, e_grant); end
      checks++; if (got !== e_valid) begin errors++; $display("FAIL rnd_valid@%0d: got %b want %b", cyc, got, e_valid); end
      if (e_valid != '0) begin
        checks++;
        if (req_out[e_sel].addr !== e_addr || req_out[e_sel].is_write !== e_head.wr || req_out[e_sel].size !== e_head.size) begin
          errors++; $display("FAIL rnd_req@%0d: got ch%0d %h w%b s%0d want %h w%b s%0d", cyc, e_sel,
                             req_out[e_sel].addr, req_out[e_sel].is_write, req_out[e_sel].size, e_addr, e_head.wr, e_head.size);
        end
      end
      checks++; if (tag_out.valid !== e_tag) begin errors++; $display("FAIL rnd_tag@%0d: got %b want %b", cyc, tag_out.valid, e_tag); end
      if (e_tag) begin
        checks++;
        if (int'(tag_out.channel) != e_sel || tag_out.app !== e_head.app || tag_out.port !== e_head.port || tag_out.size !== e_head.size) begin
          errors++; $display("FAIL rnd_tagdata@%0d: got ch%0d app%0d port%0d want ch%0d app%0d port%0d", cyc,
                             tag_out.channel, tag_out.app, tag_out.port, e_sel, e_head.app, e_head.port);
        end
      end
      checks++; if (fault !== m_fault || fault_count !== 16'(m_fcount)) begin errors++; $display("FAIL rnd_fault@%0d: got %b/%0d want %b/%0d", cyc, fault, fault_count, m_fault, m_fcount); end
      model_commit();
      to_drive();
    end
    rst_n = 1'b1; drive_idle();
  endtask

  initial begin
    test_reset();
    test_intlv_read();
    test_intlv_write();
    test_fault();
    test_credit();
    test_tag_full();
    test_full();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
